// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store, with a response watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data requests always win.
module mem_port_arbiter #(
    parameter int unsigned WATCHDOG_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        d_misalign,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        timeout
);

    localparam logic [15:0] WD_LIMIT = 16'(WATCHDOG_CYCLES);

    typedef enum logic [1:0] {IDLE, IFETCH, DATA, ERR} state_t;

    state_t      state, state_next;
    logic [15:0] wd_cnt;
    logic        is_store;
    logic        d_req, grant, grant_data, access_ok;
    logic        active, at_limit, expired;
    logic [3:0]  be_calc;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^if_addr[1:0];
    assign d_req            = d_read | d_write;
    assign grant            = (state == IDLE) & (d_req | if_read);

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_data;
    assign grant_data = d_req & (~if_read | prio_data);

    // Priority passes to whichever requester was not served by the latest grant.
    always_ff @(posedge clk) begin
        if (rst)        prio_data <= 1'b1;
        else if (grant) prio_data <= ~grant_data;
    end
`else
    assign grant_data = d_req;
`endif

    // Width decode: a store with a load-only code counts as undefined.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        be_calc   = '0;
        access_ok = 1'b0;
        case (d_funct3)
            3'b000: begin access_ok = 1'b1;                    be_calc = 4'b0001 << d_addr[1:0]; end
            3'b100: begin access_ok = ~d_write;                be_calc = 4'b0001 << d_addr[1:0]; end
            3'b001: begin access_ok = ~d_addr[0];              be_calc = 4'b0011 << d_addr[1:0]; end
            3'b101: begin access_ok = ~d_write & ~d_addr[0];   be_calc = 4'b0011 << d_addr[1:0]; end
            3'b010: begin access_ok = (d_addr[1:0] == 2'b00);  be_calc = 4'b1111;                end
            default: ;
        endcase
        if (!access_ok) be_calc = '0;
    end

    assign active   = (state == IFETCH) | (state == DATA);
    assign at_limit = active & (wd_cnt == WD_LIMIT);
    // A response arriving in the expiry cycle still wins over the abort.
    assign expired  = at_limit & ~mem_resp;
    assign if_rdata = expired ? 32'h0 : mem_rdata;
    assign d_rdata  = expired ? 32'h0 : mem_rdata;

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if_resp    = 1'b0;
        d_resp     = 1'b0;
        d_misalign = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_next = grant_data ? (access_ok ? DATA : ERR) : IFETCH;
            end
            IFETCH: begin
                mem_read = ~at_limit;
                if_resp  = mem_resp | at_limit;
                timeout  = expired;
                if (mem_resp || at_limit) state_next = IDLE;
            end
            DATA: begin
                mem_read  = ~at_limit & ~is_store;
                mem_write = ~at_limit & is_store;
                d_resp    = mem_resp | at_limit;
                timeout   = expired;
                if (mem_resp || at_limit) state_next = IDLE;
            end
            ERR: begin
                d_resp     = 1'b1;
                d_misalign = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state           <= IDLE;
            wd_cnt          <= '0;
            is_store        <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                wd_cnt          <= '0;
                mem_address     <= grant_data ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
                mem_wdata       <= d_wdata;
                mem_byte_enable <= grant_data ? be_calc : 4'b1111;
                is_store        <= grant_data & d_write;
            end else if (active && !mem_resp && !at_limit) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end

endmodule
